// File: rtl/isa_pkg.sv
// Shared instruction-set definitions: field widths, opcode encodings,
// opcode legality and the loader state encoding. The control decoder
// uses the same opcode constants so writer and reader agree on the format.
package isa_pkg;

  localparam int OPW  = 4;
  localparam int ARGW = 5;
  localparam int IW   = OPW + ARGW;

  typedef enum logic [3:0] {
    OP_JMP   = 4'b0000,
    OP_JEQ   = 4'b0001,
    OP_JNE   = 4'b0010,
    OP_JLT   = 4'b0011,
    OP_JGE   = 4'b0100,
    OP_ADD   = 4'b0101,
    OP_XOR   = 4'b0110,
    OP_STORE = 4'b0111,
    OP_LOAD  = 4'b1000,
    OP_MOVF  = 4'b1010,
    OP_CMP   = 4'b1100,
    OP_LSL   = 4'b1101,
    OP_MOVI  = 4'b1110
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_OVF  = 2'd3
  } ld_state_e;

  // 1001, 1011 and 1111 are unassigned encodings
  function automatic logic is_legal_op(input logic [OPW-1:0] op);
    logic legal;
    case (op)
      OP_JMP, OP_JEQ, OP_JNE, OP_JLT, OP_JGE,
      OP_ADD, OP_XOR, OP_STORE, OP_LOAD,
      OP_MOVF, OP_CMP, OP_LSL, OP_MOVI: legal = 1'b1;
      default:                          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: accepts opcode/operand pairs over a
// valid/ready handshake, drops illegal opcodes, packs legal ones into
// machine words and writes them sequentially from address 0 through a
// registered one-cycle-latency write port.
module instr_encoder_loader #(
  parameter int OPW  = isa_pkg::OPW,
  parameter int ARGW = isa_pkg::ARGW,
  parameter int IW   = isa_pkg::IW,
  parameter int AW   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_op,
  input  logic [ARGW-1:0] in_arg,
  input  logic            in_last,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [IW-1:0]   mem_wdata,
  output logic            done,
  output logic            err_illegal,
  output logic            err_overflow,
  output logic [AW:0]     word_count
);
  import isa_pkg::*;

  localparam logic [AW-1:0] ADDR_MAX = '1;

  ld_state_e       state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW:0]     wcount_q, wcount_d;
  logic            err_ill_q, err_ill_d;
  logic            we_q, we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [IW-1:0]   wdata_q, wdata_d;

  logic            loading;
  logic            accept;
  logic            legal;
  logic            restart;

  assign loading = (state_q == ST_LOAD);
  assign accept  = loading & in_valid;
  assign legal   = is_legal_op(in_op);
  // start only has an effect outside LOAD
  assign restart = start & ~loading;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a last word ends the load even if illegal; a legal write
  // into the top address without last ends in overflow
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_OVF: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (accept) begin
          if (in_last)                         state_d = ST_DONE;
          else if (legal && addr_q == ADDR_MAX) state_d = ST_OVF;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are decoded from the state register only
  always_comb begin
    in_ready     = loading;
    done         = (state_q == ST_DONE);
    err_overflow = (state_q == ST_OVF);
    err_illegal  = err_ill_q;
    word_count   = wcount_q;
    mem_we       = we_q;
    mem_addr     = waddr_q;
    mem_wdata    = wdata_q;
  end

  // Address counter, word counter, sticky illegal flag and write port
  always_comb begin
    addr_d    = addr_q;
    wcount_d  = wcount_q;
    err_ill_d = err_ill_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    if (restart) begin
      addr_d    = '0;
      wcount_d  = '0;
      err_ill_d = 1'b0;
    end
    if (accept) begin
      if (legal) begin
        we_d     = 1'b1;
        waddr_d  = addr_q;
        wdata_d  = {in_op, in_arg};
        wcount_d = wcount_q + (AW+1)'(1);
        // hold at the top address instead of wrapping; the FSM leaves LOAD
        if (addr_q != ADDR_MAX) addr_d = addr_q + AW'(1);
      end else begin
        err_ill_d = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      wcount_q  <= '0;
      err_ill_q <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      addr_q    <= addr_d;
      wcount_q  <= wcount_d;
      err_ill_q <= err_ill_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Testbench for instr_encoder_loader: a full-size (AW=8) and a tiny (AW=2)
// instance share the input bus; each has its own start. Programs are
// checked against a word-list reference model of the loader.
module tb_instr_encoder_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start8 = 1'b0, start2 = 1'b0;
  logic       in_valid = 1'b0, in_last = 1'b0;
  logic [3:0] in_op = '0;
  logic [4:0] in_arg = '0;

  logic       rdy8, we8, done8, ill8, ovf8;
  logic [7:0] addr8;
  logic [8:0] data8, wc8;
  logic       rdy2, we2, done2, ill2, ovf2;
  logic [1:0] addr2;
  logic [8:0] data2;
  logic [2:0] wc2;

  instr_encoder_loader #(.AW(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .in_valid(in_valid),
    .in_ready(rdy8), .in_op(in_op), .in_arg(in_arg), .in_last(in_last),
    .mem_we(we8), .mem_addr(addr8), .mem_wdata(data8), .done(done8),
    .err_illegal(ill8), .err_overflow(ovf8), .word_count(wc8)
  );

  instr_encoder_loader #(.AW(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .in_valid(in_valid),
    .in_ready(rdy2), .in_op(in_op), .in_arg(in_arg), .in_last(in_last),
    .mem_we(we2), .mem_addr(addr2), .mem_wdata(data2), .done(done2),
    .err_illegal(ill2), .err_overflow(ovf2), .word_count(wc2)
  );

  // view of the instance under test (which=1 selects the AW=2 instance)
  logic       which = 1'b0;
  logic       v_rdy, v_we, v_done, v_ill, v_ovf;
  logic [7:0] v_addr;
  logic [8:0] v_data, v_wc;
  always_comb begin
    if (which) begin
      v_rdy = rdy2; v_we = we2; v_done = done2; v_ill = ill2; v_ovf = ovf2;
      v_addr = {6'b0, addr2}; v_data = data2; v_wc = {6'b0, wc2};
    end else begin
      v_rdy = rdy8; v_we = we8; v_done = done8; v_ill = ill8; v_ovf = ovf8;
      v_addr = addr8; v_data = data8; v_wc = wc8;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // write log of the selected instance
  bit         mon_en = 1'b0;
  int         lg_cyc[$];
  logic [7:0] lg_addr[$];
  logic [8:0] lg_data[$];
  logic       lg_done[$];
  logic       lg_ovf[$];
  always @(negedge clk) begin
    if (mon_en && v_we === 1'b1) begin
      lg_cyc.push_back(cyc);
      lg_addr.push_back(v_addr);
      lg_data.push_back(v_data);
      lg_done.push_back(v_done);
      lg_ovf.push_back(v_ovf);
    end
  end

  // program under test
  logic [3:0] p_op[32];
  logic [4:0] p_arg[32];
  logic       p_last[32];
  int         p_n;

  function automatic bit ref_legal(input logic [3:0] op);
    return !(op inside {4'd9, 4'd11, 4'd15});
  endfunction

  // Start a load, present every program word (with random idle gaps up to
  // gmax), then compare the write log and final status with the model.
  task automatic run_prog(input int gmax);
    int         depth, nw, end_kind;
    bit         ended, ill, last_wrote;
    bit         exp_acc[32];
    int         c_acc[32];
    int         e_src[32];
    logic [8:0] e_data[32];
    bit         e_d, e_o;
    depth = which ? 4 : 256;
    nw = 0; end_kind = 0; ended = 0; ill = 0; last_wrote = 0;
    for (int i = 0; i < p_n; i++) begin
      exp_acc[i] = !ended;
      if (!ended) begin
        if (ref_legal(p_op[i])) begin
          e_src[nw] = i; e_data[nw] = {p_op[i], p_arg[i]}; nw++; last_wrote = 1;
        end else begin
          ill = 1; last_wrote = 0;
        end
        if (p_last[i]) begin
          ended = 1; end_kind = 1;
        end else if (last_wrote && nw == depth) begin
          ended = 1; end_kind = 2;
        end
      end
    end

    lg_cyc.delete(); lg_addr.delete(); lg_data.delete(); lg_done.delete(); lg_ovf.delete();
    mon_en = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    if (which) start2 = 1'b1; else start8 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; start8 = 1'b0;
    n_chk++; if (v_rdy !== 1'b1) $display("FAIL start_ready got %b exp 1", v_rdy); else n_pass++;
    n_chk++; if (v_done !== 1'b0) $display("FAIL start_done got %b exp 0", v_done); else n_pass++;
    n_chk++; if (v_ill !== 1'b0) $display("FAIL start_illegal got %b exp 0", v_ill); else n_pass++;
    n_chk++; if (v_ovf !== 1'b0) $display("FAIL start_ovf got %b exp 0", v_ovf); else n_pass++;
    n_chk++; if (v_wc !== 9'd0) $display("FAIL start_count got %0d exp 0", v_wc); else n_pass++;

    for (int i = 0; i < p_n; i++) begin
      repeat ($urandom_range(0, gmax)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1; in_op = p_op[i]; in_arg = p_arg[i]; in_last = p_last[i];
      n_chk++;
      if (v_rdy !== exp_acc[i]) $display("FAIL ready_w%0d got %b exp %b", i, v_rdy, exp_acc[i]);
      else n_pass++;
      c_acc[i] = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1'b0;

    n_chk++;
    if (lg_addr.size() != nw) $display("FAIL write_count got %0d exp %0d", lg_addr.size(), nw);
    else n_pass++;
    for (int j = 0; j < nw && j < lg_addr.size(); j++) begin
      e_d = (end_kind == 1) && last_wrote && (j == nw - 1);
      e_o = (end_kind == 2) && (j == nw - 1);
      n_chk++; if (lg_addr[j] !== 8'(j)) $display("FAIL wr%0d_addr got %0h exp %0h", j, lg_addr[j], 8'(j)); else n_pass++;
      n_chk++; if (lg_data[j] !== e_data[j]) $display("FAIL wr%0d_data got %0h exp %0h", j, lg_data[j], e_data[j]); else n_pass++;
      n_chk++; if (lg_cyc[j] !== c_acc[e_src[j]] + 1) $display("FAIL wr%0d_cycle got %0d exp %0d", j, lg_cyc[j], c_acc[e_src[j]] + 1); else n_pass++;
      n_chk++; if (lg_done[j] !== e_d) $display("FAIL wr%0d_done got %b exp %b", j, lg_done[j], e_d); else n_pass++;
      n_chk++; if (lg_ovf[j] !== e_o) $display("FAIL wr%0d_ovf got %b exp %b", j, lg_ovf[j], e_o); else n_pass++;
    end
    n_chk++; if (v_done !== (end_kind == 1)) $display("FAIL end_done got %b exp %b", v_done, end_kind == 1); else n_pass++;
    n_chk++; if (v_ovf !== (end_kind == 2)) $display("FAIL end_ovf got %b exp %b", v_ovf, end_kind == 2); else n_pass++;
    n_chk++; if (v_ill !== ill) $display("FAIL end_illegal got %b exp %b", v_ill, ill); else n_pass++;
    n_chk++; if (v_wc !== 9'(nw)) $display("FAIL end_count got %0d exp %0d", v_wc, nw); else n_pass++;
    n_chk++; if (v_rdy !== (end_kind == 0)) $display("FAIL end_ready got %b exp %b", v_rdy, end_kind == 0); else n_pass++;
  endtask

  task automatic set_word(input int i, input logic [3:0] op, input logic [4:0] arg, input logic last);
    p_op[i] = op; p_arg[i] = arg; p_last[i] = last;
  endtask

  task automatic gen_random(input int maxn);
    p_n = $urandom_range(1, maxn);
    for (int i = 0; i < p_n; i++) begin
      p_op[i]   = 4'($urandom_range(0, 15));
      p_arg[i]  = 5'($urandom_range(0, 31));
      p_last[i] = (i == p_n - 1) || ($urandom_range(0, 9) == 0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start8 = 1'b0; start2 = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if ({rdy8, we8, done8, ill8, ovf8} !== 5'b0) $display("FAIL rst8_flags got %b exp 00000", {rdy8, we8, done8, ill8, ovf8}); else n_pass++;
    n_chk++; if (addr8 !== 8'd0) $display("FAIL rst8_addr got %0h exp 0", addr8); else n_pass++;
    n_chk++; if (data8 !== 9'd0) $display("FAIL rst8_data got %0h exp 0", data8); else n_pass++;
    n_chk++; if (wc8 !== 9'd0) $display("FAIL rst8_count got %0d exp 0", wc8); else n_pass++;
    n_chk++; if ({rdy2, we2, done2, ill2, ovf2} !== 5'b0) $display("FAIL rst2_flags got %b exp 00000", {rdy2, we2, done2, ill2, ovf2}); else n_pass++;
    n_chk++; if (addr2 !== 2'd0) $display("FAIL rst2_addr got %0h exp 0", addr2); else n_pass++;
    n_chk++; if (data2 !== 9'd0) $display("FAIL rst2_data got %0h exp 0", data2); else n_pass++;
    n_chk++; if (wc2 !== 3'd0) $display("FAIL rst2_count got %0d exp 0", wc2); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_load();
    which = 1'b0;
    p_n = 3;
    set_word(0, 4'b0101, 5'b00011, 1'b0);
    set_word(1, 4'b1110, 5'b10101, 1'b0);
    set_word(2, 4'b0000, 5'b00010, 1'b1);
    run_prog(0);
    if (lg_data.size() == 3) begin
      n_chk++; if (lg_data[0] !== 9'h0A3) $display("FAIL basic_w0 got %0h exp 0a3", lg_data[0]); else n_pass++;
      n_chk++; if (lg_data[1] !== 9'h1D5) $display("FAIL basic_w1 got %0h exp 1d5", lg_data[1]); else n_pass++;
      n_chk++; if (lg_data[2] !== 9'h002) $display("FAIL basic_w2 got %0h exp 002", lg_data[2]); else n_pass++;
    end
  endtask

  task automatic test_illegal_drop();
    which = 1'b0;
    p_n = 2;
    set_word(0, 4'b1011, 5'b00000, 1'b0);
    set_word(1, 4'b1000, 5'b00001, 1'b1);
    run_prog(0);
    if (lg_data.size() == 1) begin
      n_chk++; if (lg_data[0] !== 9'h101) $display("FAIL illegal_w0 got %0h exp 101", lg_data[0]); else n_pass++;
    end
  endtask

  task automatic test_overflow();
    which = 1'b1;
    p_n = 5;
    for (int i = 0; i < 5; i++) set_word(i, 4'(5 + i), 5'(3 * i + 1), 1'b0);
    run_prog(0);
  endtask

  task automatic test_exact_full();
    which = 1'b1;
    p_n = 4;
    for (int i = 0; i < 4; i++) set_word(i, 4'(12 + (i % 3)), 5'(7 * i), i == 3);
    run_prog(1);
  endtask

  task automatic test_reset_midload();
    which = 1'b0;
    @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    in_valid = 1'b1; in_op = 4'd5; in_arg = 5'd1; in_last = 1'b0;
    @(negedge clk);
    in_op = 4'd6; in_arg = 5'd2;
    @(negedge clk);
    n_chk++; if (v_we !== 1'b1 || v_addr !== 8'd1) $display("FAIL midload_wr got we=%b addr=%0h exp we=1 addr=1", v_we, v_addr); else n_pass++;
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_chk++; if ({v_rdy, v_we, v_done, v_ill, v_ovf} !== 5'b0) $display("FAIL midrst_flags got %b exp 00000", {v_rdy, v_we, v_done, v_ill, v_ovf}); else n_pass++;
    n_chk++; if (v_addr !== 8'd0 || v_data !== 9'd0) $display("FAIL midrst_port got %0h/%0h exp 0/0", v_addr, v_data); else n_pass++;
    n_chk++; if (v_wc !== 9'd0) $display("FAIL midrst_count got %0d exp 0", v_wc); else n_pass++;
    in_valid = 1'b1; in_op = 4'd5;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_chk++; if (v_we !== 1'b0 || v_rdy !== 1'b0) $display("FAIL idle_quiet%0d got we=%b rdy=%b exp 0/0", k, v_we, v_rdy); else n_pass++;
    end
    in_valid = 1'b0;
    p_n = 2;
    set_word(0, 4'd13, 5'd9, 1'b0);
    set_word(1, 4'd7, 5'd30, 1'b1);
    run_prog(0);
  endtask

  task automatic test_restart_after_error();
    which = 1'b0;
    p_n = 3;
    set_word(0, 4'd15, 5'd4, 1'b0);
    set_word(1, 4'd10, 5'd17, 1'b0);
    set_word(2, 4'd9, 5'd3, 1'b1);
    run_prog(0);
    gen_random(6);
    run_prog(0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      which = 1'b0;
      gen_random(20);
      run_prog(r % 3);
      which = 1'b1;
      gen_random(8);
      run_prog(r % 2);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_illegal_drop();
    test_overflow();
    test_exact_full();
    test_reset_midload();
    test_restart_after_error();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder/writer counterpart of the control decoder: accepts instruction fields (opcode + operand), checks that the opcode is legal, and packs them into machine words.
- Writes the words sequentially into instruction memory starting at address 0.
- Sits between the testbench/boot stream and the instruction ROM/RAM, so that the fetch → decode path reads exactly what this block wrote.
- Handles the valid/ready handshake, address counting, end-of-program, overflow and illegal-opcode reporting.

Parameters:
- OPW, 4, opcode field width (instruction bits [IW-1 -: OPW]).
- ARGW, 5, operand field width (bits [ARGW-1:0]).
- IW, 9, machine word width; must equal OPW+ARGW.
- AW, 8, instruction memory address width; depth = 2**AW.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- start  in  1  pulse; begins a new load at address 0.
- in_valid  in  1  input field pair valid.
- in_ready  out  1  block can accept a field pair this cycle.
- in_op  in  OPW  opcode.
- in_arg  in  ARGW  operand (register index / immediate / jump-table index).
- in_last  in  1  marks the final instruction of the program.
- mem_we  out  1  instruction memory write strobe.
- mem_addr  out  AW  write address.
- mem_wdata  out  IW  packed word {in_op, in_arg}.
- done  out  1  level; load completed successfully.
- err_illegal  out  1  sticky; at least one illegal opcode was dropped.
- err_overflow  out  1  level; memory full before in_last was seen.
- word_count  out  AW+1  number of words written in the current load.

Behaviour:
- Reset (synchronous) sets state IDLE and drives all outputs to 0: in_ready, mem_we, mem_addr, mem_wdata, done, err_illegal, err_overflow, word_count. Reset mid-load aborts immediately; partially written memory is left as is.
- States:
  - IDLE: in_ready=0. start → LOAD, and clears the address counter, word_count, err_illegal and done.
  - LOAD: in_ready=1. An accept happens when in_valid & in_ready are both high in the same cycle.
  - DONE: done=1, in_ready=0. start → LOAD (new load; clears as in IDLE).
  - OVF: err_overflow=1, in_ready=0. start → LOAD (new load; clears err_overflow).
- start is ignored while in LOAD.
- Legal opcodes:
  - 0000 unconditional jump; 0001–0100 conditional jumps.
  - 0101 add; 0110 xor; 0111 store; 1000 load; 1010 movf; 1100 cmp; 1101 lsl; 1110 movi.
  - Illegal: 1001, 1011, 1111.
- Legal accept: on the next cycle mem_we=1 for exactly one cycle, with mem_addr = current address and mem_wdata = {in_op, in_arg}. Then address += 1 and word_count += 1. Write latency is 1 cycle, registered.
- Illegal accept: no write, address unchanged, err_illegal set (sticky).
- in_last on an accept (legal or illegal) → DONE on the following cycle, with done asserted in that same cycle as the final mem_we. An illegal last word still ends the load.
- Overflow: after the write to address 2**AW-1 without in_last, go to OVF. word_count saturates at 2**AW; the address does not wrap. A legal in_last word at address 2**AW-1 → DONE, not OVF.
- Back-to-back accepts are allowed: one word per cycle sustained, no bubbles.
- in_ready is a pure function of state; it does not depend on in_valid.

Decomposition:
- Shared package (isa_pkg):
  - Opcode localparams/enum: OP_JMP, OP_JEQ, …, OP_MOVI.
  - IW, OPW, ARGW constants.
  - Function is_legal_op(op).
  - Loader state enum {IDLE, LOAD, DONE, OVF}.
- The control decoder uses the same opcode constants.
- No sub-module is needed; one flat module of FSM, address counter and registered write port.

Test Plan:
- reset, start, 3 accepts (0101/00011, 1110/10101, 0000/00010 with in_last) → writes addr0=0x0A3, addr1=0x1D5, addr2=0x002 on consecutive cycles; done=1 with the third write; word_count=3.
- start, accept op=1011 arg=0, then 1000/00001 with in_last → only addr0=0x101 written; err_illegal=1; done=1; word_count=1.
- AW=2, start, 5 legal words with no in_last → writes addr0..3, then OVF: err_overflow=1, in_ready=0, word_count=4, no 5th write.
- AW=2, 4 legal words with in_last on the 4th → DONE, err_overflow=0.
- Reset asserted on the cycle after the 2nd accept of a load → next cycle all outputs are 0 and state is IDLE; no further writes; start restarts at addr0.
- In DONE with err_illegal=1, pulse start → err_illegal=0, done=0, word_count=0; the first accept writes addr0.
